// File: rtl/predictor_update_ctrl_pkg.sv
// Shared definitions for the branch-predictor update controller: bus/queue sizing,
// the arbitration priority type and the per-requester slot-grant rule.
package predictor_update_ctrl_pkg;

  localparam int ADDRESS_BUS_W   = 32;
  localparam int BPU_QUEUE_DEPTH = 4;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  // A requester may take a slot when two are free, or when only one is free and
  // it either has no competitor this cycle or currently holds priority.
  function automatic logic slot_grant(input logic free_ge2,
                                      input logic free_eq1,
                                      input logic other_valid,
                                      input logic has_prio);
    return free_ge2 | (free_eq1 & (~other_valid | has_prio));
  endfunction

endpackage

// File: rtl/predictor_update_ctrl_bpu_update_fifo.sv
// Two-write / one-read circular FIFO with a registered occupancy count.
// Storage is intentionally left unreset; only pointers and count are cleared.
module bpu_update_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     clear_in,
  input  logic                     push0_en,
  input  logic [W-1:0]             push0_data,
  input  logic                     push1_en,
  input  logic [W-1:0]             push1_data,
  input  logic                     pop_en,
  output logic [W-1:0]             head_data,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_next1;
  logic [CW-1:0] count;

  // push1 only ever fires together with push0, so it lands in the slot after it
  assign wr_ptr_next1 = wr_ptr + 1'b1;
  assign head_data    = mem[rd_ptr];
  assign count_out    = count;

  always_ff @(posedge clk_in) begin
    if (push0_en) mem[wr_ptr] <= push0_data;
    if (push1_en) mem[wr_ptr_next1] <= push1_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push0_en) + PW'(push1_en);
      rd_ptr <= rd_ptr + PW'(pop_en);
      count  <= count + CW'(push0_en) + CW'(push1_en) - CW'(pop_en);
    end
  end

endmodule

// File: rtl/predictor_update_ctrl.sv
// Arbitrates branch (A) and jump (B) resolution updates into a small FIFO and
// drains them to the predictor write port, keeping wrapping statistics counters.
module predictor_update_ctrl
  import predictor_update_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDRESS_BUS_W,
  parameter int DEPTH  = BPU_QUEUE_DEPTH
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   clear_in,
  input  logic                   a_valid_in,
  input  logic [ADDR_W-1:0]      a_pc_in,
  input  logic [ADDR_W-1:0]      a_target_in,
  input  logic                   a_taken_in,
  output logic                   a_ready_out,
  input  logic                   b_valid_in,
  input  logic [ADDR_W-1:0]      b_pc_in,
  input  logic [ADDR_W-1:0]      b_target_in,
  input  logic                   b_taken_in,
  output logic                   b_ready_out,
  output logic                   wr_en_out,
  output logic [ADDR_W-1:0]      wr_pc_out,
  output logic [ADDR_W-1:0]      wr_target_out,
  output logic                   wr_taken_out,
  output logic [$clog2(DEPTH):0] count_out,
  output logic [31:0]            upd_cnt_out,
  output logic [31:0]            taken_cnt_out
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 2 * ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  prio_e         prio;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          free_ge2;
  logic          free_eq1;
  logic          a_acc;
  logic          b_acc;
  logic          pop;
  logic          push0_en;
  logic          push1_en;
  logic [EW-1:0] a_entry;
  logic [EW-1:0] b_entry;
  logic [EW-1:0] push0_data;
  logic [EW-1:0] head;

  // Free space comes from the registered count only, so a same-cycle pop never
  // opens a slot early.
  assign free     = DEPTH_CNT - count;
  assign free_ge2 = (free >= CW'(2));
  assign free_eq1 = (free == CW'(1));

  assign a_ready_out = rdy_in & ~clear_in &
                       slot_grant(free_ge2, free_eq1, b_valid_in, prio == PRIO_A);
  assign b_ready_out = rdy_in & ~clear_in &
                       slot_grant(free_ge2, free_eq1, a_valid_in, prio == PRIO_B);

  assign a_acc = a_valid_in & a_ready_out;
  assign b_acc = b_valid_in & b_ready_out;
  assign pop   = rdy_in & ~clear_in & (count != '0);

  assign a_entry = {a_pc_in, a_target_in, a_taken_in};
  assign b_entry = {b_pc_in, b_target_in, b_taken_in};

  // When both are accepted A occupies the first slot and B the one behind it.
  assign push0_en   = a_acc | b_acc;
  assign push0_data = a_acc ? a_entry : b_entry;
  assign push1_en   = a_acc & b_acc;

  assign count_out = count;

  bpu_update_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .clear_in   (clear_in),
    .push0_en   (push0_en),
    .push0_data (push0_data),
    .push1_en   (push1_en),
    .push1_data (b_entry),
    .pop_en     (pop),
    .head_data  (head),
    .count_out  (count)
  );

  // Output register, priority bit and statistics all freeze while rdy_in is low;
  // a flush still drops the pending write and resets priority.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_en_out     <= 1'b0;
      wr_pc_out     <= '0;
      wr_target_out <= '0;
      wr_taken_out  <= 1'b0;
      prio          <= PRIO_A;
      upd_cnt_out   <= '0;
      taken_cnt_out <= '0;
    end else if (clear_in) begin
      wr_en_out <= 1'b0;
      prio      <= PRIO_A;
    end else if (rdy_in) begin
      wr_en_out <= pop;
      if (pop) begin
        {wr_pc_out, wr_target_out, wr_taken_out} <= head;
        upd_cnt_out   <= upd_cnt_out + 32'd1;
        taken_cnt_out <= taken_cnt_out + 32'(head[0]);
      end
      if (a_valid_in & b_valid_in & free_eq1)
        prio <= (prio == PRIO_A) ? PRIO_B : PRIO_A;
    end
  end

endmodule

// File: tb/tb_predictor_update_ctrl.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_predictor_update_ctrl;

  localparam int DEPTH = 4;

  typedef struct {
    bit          rdy;
    bit          clr;
    bit          av;
    logic [31:0] apc;
    logic [31:0] atgt;
    bit          atk;
    bit          bv;
    logic [31:0] bpc;
    logic [31:0] btgt;
    bit          btk;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    bit          tk;
  } ent_t;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic        clear_in = 1'b0;
  logic        a_valid_in = 1'b0;
  logic [31:0] a_pc_in = '0;
  logic [31:0] a_target_in = '0;
  logic        a_taken_in = 1'b0;
  logic        a_ready_out;
  logic        b_valid_in = 1'b0;
  logic [31:0] b_pc_in = '0;
  logic [31:0] b_target_in = '0;
  logic        b_taken_in = 1'b0;
  logic        b_ready_out;
  logic        wr_en_out;
  logic [31:0] wr_pc_out;
  logic [31:0] wr_target_out;
  logic        wr_taken_out;
  logic [2:0]  count_out;
  logic [31:0] upd_cnt_out;
  logic [31:0] taken_cnt_out;

  int n_cmp = 0;
  int n_fail = 0;

  ent_t        mq[$];
  bit          m_wr_en;
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  bit          m_tk;
  bit          m_prio_b;
  int unsigned m_upd;
  int unsigned m_tkn;
  bit          exp_a;
  bit          exp_b;

  predictor_update_ctrl dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .clear_in      (clear_in),
    .a_valid_in    (a_valid_in),
    .a_pc_in       (a_pc_in),
    .a_target_in   (a_target_in),
    .a_taken_in    (a_taken_in),
    .a_ready_out   (a_ready_out),
    .b_valid_in    (b_valid_in),
    .b_pc_in       (b_pc_in),
    .b_target_in   (b_target_in),
    .b_taken_in    (b_taken_in),
    .b_ready_out   (b_ready_out),
    .wr_en_out     (wr_en_out),
    .wr_pc_out     (wr_pc_out),
    .wr_target_out (wr_target_out),
    .wr_taken_out  (wr_taken_out),
    .count_out     (count_out),
    .upd_cnt_out   (upd_cnt_out),
    .taken_cnt_out (taken_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(bit rdy, bit clr, bit av, logic [31:0] apc, logic [31:0] atgt,
                               bit atk, bit bv, logic [31:0] bpc, logic [31:0] btgt, bit btk);
    stim_t s;
    s.rdy = rdy; s.clr = clr;
    s.av = av; s.apc = apc; s.atgt = atgt; s.atk = atk;
    s.bv = bv; s.bpc = bpc; s.btgt = btgt; s.btk = btk;
    return s;
  endfunction

  function automatic stim_t idle(bit rdy);
    return mk(rdy, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_wr_en = 1'b0; m_pc = '0; m_tgt = '0; m_tk = 1'b0;
    m_prio_b = 1'b0; m_upd = 0; m_tkn = 0;
  endtask

  task automatic calc_readies(input stim_t s);
    int fr;
    fr = DEPTH - mq.size();
    exp_a = s.rdy && !s.clr && (fr >= 2 || (fr == 1 && (!s.bv || !m_prio_b)));
    exp_b = s.rdy && !s.clr && (fr >= 2 || (fr == 1 && (!s.av || m_prio_b)));
  endtask

  // One clock edge of the reference: pop the old head first, then append accepted updates.
  task automatic model_step(input stim_t s);
    int   fr;
    ent_t h;
    if (s.clr) begin
      mq.delete();
      m_wr_en = 1'b0;
      m_prio_b = 1'b0;
    end else if (s.rdy) begin
      fr = DEPTH - mq.size();
      if (mq.size() > 0) begin
        h = mq.pop_front();
        m_wr_en = 1'b1; m_pc = h.pc; m_tgt = h.tgt; m_tk = h.tk;
        m_upd++;
        if (h.tk) m_tkn++;
      end else begin
        m_wr_en = 1'b0;
      end
      if (s.av && exp_a) mq.push_back('{s.apc, s.atgt, s.atk});
      if (s.bv && exp_b) mq.push_back('{s.bpc, s.btgt, s.btk});
      if (s.av && s.bv && fr == 1) m_prio_b = !m_prio_b;
    end
  endtask

  task automatic checkOutput();
    cmp("a_ready", a_ready_out, exp_a);
    cmp("b_ready", b_ready_out, exp_b);
    cmp("wr_en", wr_en_out, m_wr_en);
    cmp("wr_pc", wr_pc_out, m_pc);
    cmp("wr_target", wr_target_out, m_tgt);
    cmp("wr_taken", wr_taken_out, m_tk);
    cmp("count", count_out, mq.size());
    cmp("upd_cnt", upd_cnt_out, m_upd);
    cmp("taken_cnt", taken_cnt_out, m_tkn);
  endtask

  task automatic applyStimulus(input stim_t s);
    @(negedge clk_in);
    rdy_in = s.rdy; clear_in = s.clr;
    a_valid_in = s.av; a_pc_in = s.apc; a_target_in = s.atgt; a_taken_in = s.atk;
    b_valid_in = s.bv; b_pc_in = s.bpc; b_target_in = s.btgt; b_taken_in = s.btk;
    #1;
    calc_readies(s);
    checkOutput();
    model_step(s);
  endtask

  task automatic single_update_check(input string tag);
    applyStimulus(mk(1, 0, 1, 32'h100, 32'h80, 1, 0, 0, 0, 0));
    cmp({tag, "_a_ready"}, a_ready_out, 32'd1);
    applyStimulus(idle(1));
    cmp({tag, "_wr_en_n1"}, wr_en_out, 32'd0);
    cmp({tag, "_count_n1"}, count_out, 32'd1);
    applyStimulus(idle(1));
    cmp({tag, "_wr_en_n2"}, wr_en_out, 32'd1);
    cmp({tag, "_wr_pc"}, wr_pc_out, 32'h100);
    cmp({tag, "_wr_target"}, wr_target_out, 32'h80);
    cmp({tag, "_wr_taken"}, wr_taken_out, 32'd1);
    cmp({tag, "_upd_cnt"}, upd_cnt_out, 32'd1);
    cmp({tag, "_taken_cnt"}, taken_cnt_out, 32'd1);
    applyStimulus(idle(1));
    cmp({tag, "_wr_en_n3"}, wr_en_out, 32'd0);
  endtask

  initial begin
    stim_t s;
    bit    a_hold;
    bit    b_hold;

    model_reset();
    repeat (3) @(negedge clk_in);
    cmp("rst_wr_en", wr_en_out, 32'd0);
    cmp("rst_count", count_out, 32'd0);
    cmp("rst_wr_pc", wr_pc_out, 32'd0);
    cmp("rst_upd_cnt", upd_cnt_out, 32'd0);
    rst_in = 1'b1;

    $display("[TB] single update latency");
    single_update_check("t1");

    $display("[TB] simultaneous A and B");
    applyStimulus(mk(1, 0, 1, 32'h10, 32'h11, 0, 1, 32'h20, 32'h21, 0));
    cmp("t2_a_ready", a_ready_out, 32'd1);
    cmp("t2_b_ready", b_ready_out, 32'd1);
    applyStimulus(idle(1));
    applyStimulus(idle(1));
    cmp("t2_first_pc", wr_pc_out, 32'h10);
    applyStimulus(idle(1));
    cmp("t2_second_pc", wr_pc_out, 32'h20);
    cmp("t2_second_en", wr_en_out, 32'd1);
    applyStimulus(idle(1));

    $display("[TB] contention at one free slot");
    applyStimulus(mk(1, 0, 1, 32'h30, 0, 0, 1, 32'h40, 0, 0));
    applyStimulus(mk(1, 0, 1, 32'h50, 0, 0, 1, 32'h60, 0, 0));
    applyStimulus(mk(1, 0, 1, 32'h70, 0, 0, 1, 32'h80, 0, 0));
    cmp("t3_count_before", count_out, 32'd3);
    cmp("t3_first_a_ready", a_ready_out, 32'd1);
    cmp("t3_first_b_ready", b_ready_out, 32'd0);
    applyStimulus(mk(1, 0, 1, 32'h90, 0, 0, 1, 32'h80, 0, 0));
    cmp("t3_second_a_ready", a_ready_out, 32'd0);
    cmp("t3_second_b_ready", b_ready_out, 32'd1);

    $display("[TB] rdy_in held low");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(idle(0));
      cmp("t4_hold_wr_en", wr_en_out, 32'd1);
      cmp("t4_hold_pc", wr_pc_out, 32'h50);
      cmp("t4_hold_count", count_out, 32'd3);
      cmp("t4_hold_a_ready", a_ready_out, 32'd0);
    end
    applyStimulus(idle(1));
    cmp("t4_release_pc", wr_pc_out, 32'h50);
    applyStimulus(idle(1));
    cmp("t4_resume_pc", wr_pc_out, 32'h60);
    cmp("t4_resume_count", count_out, 32'd2);

    $display("[TB] clear pulse");
    applyStimulus(mk(1, 0, 1, 32'hA0, 0, 0, 1, 32'hB0, 0, 0));
    applyStimulus(mk(1, 0, 1, 32'hC0, 0, 0, 1, 32'hD0, 0, 0));
    applyStimulus(mk(1, 1, 1, 32'hE0, 0, 0, 1, 32'hF0, 0, 0));
    cmp("t5_pre_count", count_out, 32'd3);
    cmp("t5_pre_wr_en", wr_en_out, 32'd1);
    cmp("t5_a_ready", a_ready_out, 32'd0);
    cmp("t5_b_ready", b_ready_out, 32'd0);
    applyStimulus(idle(1));
    cmp("t5_count", count_out, 32'd0);
    cmp("t5_wr_en", wr_en_out, 32'd0);
    cmp("t5_upd_cnt", upd_cnt_out, 32'd10);

    $display("[TB] asynchronous reset mid-drain");
    applyStimulus(mk(1, 0, 1, 32'hE0, 0, 1, 1, 32'hF0, 0, 1));
    applyStimulus(idle(1));
    applyStimulus(idle(1));
    #2;
    rst_in = 1'b0;
    #1;
    cmp("t6_wr_en", wr_en_out, 32'd0);
    cmp("t6_wr_pc", wr_pc_out, 32'd0);
    cmp("t6_count", count_out, 32'd0);
    cmp("t6_upd_cnt", upd_cnt_out, 32'd0);
    cmp("t6_taken_cnt", taken_cnt_out, 32'd0);
    model_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    single_update_check("t6");

    $display("[TB] randomized traffic");
    a_hold = 1'b0;
    b_hold = 1'b0;
    s = idle(1);
    for (int i = 0; i < 3000; i++) begin
      s.rdy = ($urandom_range(0, 99) < 85);
      s.clr = ($urandom_range(0, 99) < 3);
      if (!a_hold) begin
        s.av = ($urandom_range(0, 99) < 55);
        s.apc = $urandom; s.atgt = $urandom; s.atk = 1'($urandom_range(0, 1));
      end
      if (!b_hold) begin
        s.bv = ($urandom_range(0, 99) < 55);
        s.bpc = $urandom; s.btgt = $urandom; s.btk = 1'($urandom_range(0, 1));
      end
      applyStimulus(s);
      a_hold = s.av && !exp_a;
      b_hold = s.bv && !exp_b;
    end
    applyStimulus(idle(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/predictor_update_ctrl.md
# predictor_update_ctrl

Arbitrates and buffers branch-resolution updates from two independent requesters onto the single write port of the branch predictor (BTB + 2-bit counters). Requester A is the branch unit (conditional branches), requester B the jump unit (JAL/JALR). Accepted updates enter a small FIFO and drain to the predictor at most one per cycle. The block also keeps wrapping update and taken counters for performance inspection.

## Interface
- `ADDR_W`, 32: address width; equals the width of `` `AddressBus ``.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clk_in` in 1: clock, rising edge.
- `rst_in` in 1: reset, asynchronous, active-low.
- `rdy_in` in 1: global ready; 0 freezes all state except `clear_in` handling.
- `clear_in` in 1: synchronous flush of all pending updates.
- `a_valid_in` in 1: requester A has an update.
- `a_pc_in` in ADDR_W: branch PC.
- `a_target_in` in ADDR_W: resolved target.
- `a_taken_in` in 1: resolved direction.
- `a_ready_out` out 1: A accepted this cycle if `a_valid_in`.
- `b_valid_in`, `b_pc_in`, `b_target_in`, `b_taken_in`, `b_ready_out`: same as A, for requester B.
- `wr_en_out` out 1: to predictor `write_enable`.
- `wr_pc_out` out ADDR_W: to predictor `write_pc`.
- `wr_target_out` out ADDR_W: to predictor `write_target`.
- `wr_taken_out` out 1: to predictor `write_taken`.
- `count_out` out log2(DEPTH)+1: FIFO occupancy.
- `upd_cnt_out` out 32: updates issued, wrapping.
- `taken_cnt_out` out 32: issued updates with taken=1, wrapping.

## Operation
- Handshake: an entry transfers on a rising edge where valid=1 and ready=1. Ready depends only on registered state, `clear_in`, `rdy_in` and the other requester's valid. Requester inputs must be held stable while valid=1 and ready=0.
- `free = DEPTH - count`, using registered count. A pop in the same cycle does not free a slot.
- `a_ready_out = rdy_in & !clear_in & (free>=2 | (free==1 & (!b_valid_in | prio==A)))`. `b_ready_out` is symmetric.
- Both requesters accepted in the same cycle: A is written first, B second.
- Priority bit `prio` resets to A. It changes only when both requesters are valid and `free==1`; after that grant, the loser gets priority.
- Pop: on an edge with `rdy_in=1` and `count>0` (count before this edge's enqueues), the head loads into the output register and `wr_en_out` becomes 1. Otherwise, with `rdy_in=1`, `wr_en_out` becomes 0.
- `rdy_in=0`: FIFO, output register, `wr_en_out`, `prio` and counters hold. A held write is consumed by the predictor once `rdy_in` returns.
- `clear_in=1` (honoured regardless of `rdy_in`):
  - count becomes 0 and pointers reset.
  - `wr_en_out` becomes 0 and `prio` becomes A.
  - Both readies are low, so no enqueue occurs.
  - Statistics counters are not cleared.
- Counters: `upd_cnt_out` increments by 1 per pop; `taken_cnt_out` increments by 1 on a pop whose entry has taken=1. Both wrap modulo 2^32.
- Count update per edge: count + enqueues (0..2) − pop (0..1). It never exceeds DEPTH by construction.

## Timing
- Reset (asynchronous, `rst_in=0`): all outputs 0; `wr_*` 0; count 0; pointers 0; `prio`=A. FIFO storage is not reset.
- Reset asserted mid-operation discards all entries immediately.
- Latency with FIFO empty, `rdy_in=1`:
  - Accept at edge N.
  - `wr_en_out`=1 after edge N+1.
  - Predictor writes at edge N+2.
- Throughput: one pop per cycle. Sustained input of 2/cycle backs up to full, then readies throttle.
- Full (count=DEPTH): both readies 0. A pop that edge makes room visible the next cycle.
- Empty: `wr_en_out` falls to 0 at the next `rdy_in=1` edge after the last pop.
- Pointers wrap modulo DEPTH.

## Structure
- `` `AddressBus `` and new `` `bpuQueueDepth `` / `` `bpuQueueCntBus `` belong in `defines.v`.
- One natural sub-module: `bpu_update_fifo`. It is a 2-write/1-read circular FIFO with registered count, holding {pc, target, taken}.
- Arbitration, output register and counters stay in the top module.

## Test plan
- Single A update, pc=0x100, target=0x80, taken=1, empty queue: `a_ready_out`=1 → `wr_en_out`=1 two edges later with pc=0x100, target=0x80, taken=1 for one cycle. Then `upd_cnt_out`=1, `taken_cnt_out`=1.
- A (pc=0x10) and B (pc=0x20) valid in the same cycle with 2+ free slots: both accepted; writes issued in order 0x10 then 0x20 on consecutive cycles.
- Fill to count=3 (DEPTH=4) with no drain (`rdy_in` low except during the fill), then A and B valid: A granted first, B next slot. On the next contention at `free==1`, B wins; at count=4 both readies are 0.
- `rdy_in` dropped for 3 cycles while `wr_en_out`=1: outputs and count hold unchanged; on release the same write completes and draining resumes.
- `clear_in` pulsed with count=3 and `wr_en_out`=1: next cycle count=0, `wr_en_out`=0, readies low during the pulse, statistics counters unchanged.
- `rst_in` asserted asynchronously mid-drain: outputs 0 immediately without a clock edge. After release, the first accepted update issues with 2-edge latency.
